// File: rtl/decomp_pkg.sv
// Shared definitions for the polynomial decomposition sequencer.
// Holds the security-level encodings, the default datapath and polynomial
// dimensions, and the controller state encoding.
package decomp_pkg;

   localparam int unsigned N_COEFF = 256;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned COEFF_W = 24;
   localparam int unsigned SKID_D  = 2;

   localparam logic [2:0] SEC_LVL_0 = 3'd0;
   localparam logic [2:0] SEC_LVL_2 = 3'd2;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } ctrl_state_e;

endpackage

// File: rtl/decomp_skid_fifo.sv
// Small read-return FIFO that absorbs coefficient RAM data while the decomposer stalls.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   clr_i     synchronous flush (pointers and count to zero)
//   push_i    write data_i at the tail
//   data_i    incoming coefficient
//   pop_i     drop the head entry (only when not empty)
//   data_o    head entry
//   count_o   occupancy
//   empty_o   occupancy is zero
module decomp_skid_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [Width-1:0]             data_i,
   input  logic                         pop_i,
   output logic [Width-1:0]             data_o,
   output logic [$clog2(Depth+1)-1:0]   count_o,
   output logic                         empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/decomp_poly_ctrl.sv
// Sequencer that streams one polynomial from the coefficient RAM through the decomposer
// and writes every (doa, dob) result pair to the result RAM at its source index.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start, sec_lvl_in           job request (sampled in idle) and its security level
//   busy, done                  job in progress / one-cycle completion pulse
//   rd_en, rd_addr, rd_data     coefficient RAM read port (1-cycle latency)
//   dec_sec_lvl, dec_valid,
//   dec_di, dec_rdy_in          issue side of the decomposer
//   dec_valid_o, dec_doa,
//   dec_dob, dec_ready_o        retire side of the decomposer
//   wr_en, wr_addr,
//   wr_doa, wr_dob              result RAM write port
module decomp_poly_ctrl
   import decomp_pkg::*;
#(
   parameter int unsigned NCoeff = N_COEFF,
   parameter int unsigned AddrW  = ADDR_W,
   parameter int unsigned CoeffW = COEFF_W,
   parameter int unsigned SkidD  = SKID_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        sec_lvl_in,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [AddrW-1:0]  rd_addr,
   input  logic [CoeffW-1:0] rd_data,
   output logic [2:0]        dec_sec_lvl,
   output logic              dec_valid,
   output logic [CoeffW-1:0] dec_di,
   input  logic              dec_rdy_in,
   input  logic              dec_valid_o,
   input  logic [CoeffW-1:0] dec_doa,
   input  logic [CoeffW-1:0] dec_dob,
   output logic              dec_ready_o,
   output logic              wr_en,
   output logic [AddrW-1:0]  wr_addr,
   output logic [CoeffW-1:0] wr_doa,
   output logic [CoeffW-1:0] wr_dob
);

   localparam int unsigned   CntW      = $clog2(SkidD + 1);
   localparam logic [AddrW:0] NCoeffCnt = (AddrW + 1)'(NCoeff);

   ctrl_state_e      state_q, state_d;
   logic [AddrW:0]   rd_cnt_q, rd_cnt_d;
   logic [AddrW:0]   wr_cnt_q, wr_cnt_d;
   logic [2:0]       sec_lvl_q, sec_lvl_d;
   logic             rd_pend_q;
   logic             fifo_clr;
   logic             fifo_pop;
   logic             fifo_empty;
   logic [CntW-1:0]  fifo_count;
   logic [CntW:0]    slots_used;

   decomp_skid_fifo #(
      .Depth (SkidD),
      .Width (CoeffW)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (fifo_clr),
      .push_i  (rd_pend_q),
      .data_i  (rd_data),
      .pop_i   (fifo_pop),
      .data_o  (dec_di),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign dec_valid = !fifo_empty;
   assign fifo_pop  = dec_valid && dec_rdy_in;

   // Slots committed for the next cycle: stored entries plus the read returning now.
   // A same-cycle pop frees a slot, which keeps steady-state reads at one per cycle.
   assign slots_used = (CntW + 1)'(fifo_count) + (CntW + 1)'(rd_pend_q)
                       - (CntW + 1)'(fifo_pop);

   assign rd_en   = (state_q == StRun) && (rd_cnt_q < NCoeffCnt)
                    && (slots_used < (CntW + 1)'(SkidD));
   assign rd_addr = rd_cnt_q[AddrW-1:0];

   assign dec_ready_o = (state_q == StRun) || (state_q == StDrain);
   assign wr_en       = dec_valid_o && dec_ready_o;
   assign wr_addr     = wr_cnt_q[AddrW-1:0];
   assign wr_doa      = wr_en ? dec_doa : '0;
   assign wr_dob      = wr_en ? dec_dob : '0;

   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign dec_sec_lvl = sec_lvl_q;

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      sec_lvl_d = sec_lvl_q;
      fifo_clr  = 1'b0;
      if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
      if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               rd_cnt_d  = '0;
               wr_cnt_d  = '0;
               sec_lvl_d = sec_lvl_in;
               fifo_clr  = 1'b1;
            end
         end
         StRun: begin
            if (rd_cnt_q == NCoeffCnt) state_d = StDrain;
         end
         StDrain: begin
            // Leave as the last write lands so no extra ready cycle follows it.
            if (wr_cnt_d == NCoeffCnt) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         sec_lvl_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         sec_lvl_q <= sec_lvl_d;
         rd_pend_q <= rd_en;
      end
   end

endmodule
